// File: rtl/seq_alu_pkg.sv
// Shared op codes, FSM encoding and iterator mode for the multi-cycle execute ALU.
package seq_alu_pkg;

    localparam int OP_W = 5;

    localparam logic [OP_W-1:0] ADD  = 5'd0;
    localparam logic [OP_W-1:0] SUB  = 5'd1;
    localparam logic [OP_W-1:0] XOR  = 5'd2;
    localparam logic [OP_W-1:0] ANDN = 5'd3;
    localparam logic [OP_W-1:0] ROL  = 5'd4;
    localparam logic [OP_W-1:0] SLL  = 5'd5;
    localparam logic [OP_W-1:0] ROR  = 5'd6;
    localparam logic [OP_W-1:0] SRL  = 5'd7;
    localparam logic [OP_W-1:0] SEQ  = 5'd8;
    localparam logic [OP_W-1:0] SLT  = 5'd9;
    localparam logic [OP_W-1:0] SLE  = 5'd10;
    localparam logic [OP_W-1:0] SCO  = 5'd11;
    localparam logic [OP_W-1:0] BTR  = 5'd12;
    localparam logic [OP_W-1:0] LBI  = 5'd13;
    localparam logic [OP_W-1:0] SLBI = 5'd14;
    localparam logic [OP_W-1:0] BEQZ = 5'd15;
    localparam logic [OP_W-1:0] BNEZ = 5'd16;
    localparam logic [OP_W-1:0] BLTZ = 5'd17;
    localparam logic [OP_W-1:0] BGEZ = 5'd18;
    localparam logic [OP_W-1:0] MUL  = 5'd19;
    localparam logic [OP_W-1:0] DIVU = 5'd20;
    localparam logic [OP_W-1:0] REMU = 5'd21;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        MODE_MUL = 2'd0,
        MODE_DIV = 2'd1,
        MODE_REM = 2'd2
    } iter_mode_t;

    function automatic logic is_multicycle(input logic [OP_W-1:0] op);
        return (op == MUL) || (op == DIVU) || (op == REMU);
    endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Decode-to-execute request/response bundle for seq_alu.
interface seq_alu_if
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [OP_W-1:0]  op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             flag;
    logic             err;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, flag, err
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, flag, err
    );
endinterface

// File: rtl/seq_alu_iter.sv
// Shared shift-add multiplier / restoring divider, one step per cycle.
// The first step is taken on the start cycle so WIDTH steps finish WIDTH cycles later.
module seq_alu_iter
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  iter_mode_t       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW:0] LAST = (SHW+1)'(WIDTH);

    iter_mode_t       mode_q, s_mode;
    logic             active_q;
    logic [SHW:0]     cnt_q;
    logic [WIDTH-1:0] acc_q, x_q, z_q;
    logic [WIDTH-1:0] s_acc, s_x, s_z;
    logic [WIDTH-1:0] n_acc, n_x, n_z;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] diff;

    assign done   = active_q && (cnt_q == LAST);
    assign s_mode = start ? mode : mode_q;
    assign s_acc  = start ? '0 : acc_q;
    assign s_x    = start ? a : x_q;
    assign s_z    = start ? b : z_q;

    // acc = product / partial remainder, x = multiplicand / dividend-quotient, z = multiplier / divisor
    assign rem_sh = {s_acc, s_x[WIDTH-1]};
    assign diff   = rem_sh[WIDTH-1:0] - s_z;

    always_comb begin
        n_acc = s_acc;
        n_x   = s_x;
        n_z   = s_z;
        if (s_mode == MODE_MUL) begin
            n_acc = s_acc + (s_z[0] ? s_x : '0);
            n_x   = s_x << 1;
            n_z   = s_z >> 1;
        end else if (rem_sh >= {1'b0, s_z}) begin
            n_acc = diff;
            n_x   = {s_x[WIDTH-2:0], 1'b1};
        end else begin
            n_acc = rem_sh[WIDTH-1:0];
            n_x   = {s_x[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            mode_q   <= MODE_MUL;
        end else if (start) begin
            active_q <= 1'b1;
            cnt_q    <= (SHW+1)'(1);
            mode_q   <= mode;
        end else if (done) begin
            active_q <= 1'b0;
        end else if (active_q) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (start || (active_q && !done)) begin
            acc_q <= n_acc;
            x_q   <= n_x;
            z_q   <= n_z;
        end
    end

    always_comb begin
        case (mode_q)
            MODE_DIV: result = x_q;
            default:  result = acc_q;
        endcase
    end
endmodule

// File: rtl/seq_alu.sv
// Multi-cycle execute ALU: single-cycle logic/shift/compare/branch ops plus
// iterative MUL/DIVU/REMU behind a valid/ready handshake.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic     clk,
    input  logic     rst_n,
    seq_alu_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);

    state_t           state_q, state_d;
    logic             in_ready, out_valid, accept, op_multi;
    logic             iter_start, iter_done;
    iter_mode_t       iter_mode;
    logic [WIDTH-1:0] iter_result;
    logic             dz_q;
    logic [WIDTH-1:0] result_q;
    logic             flag_q, err_q;

    logic [WIDTH-1:0]        sc_result;
    logic                    sc_flag, sc_err;
    logic [SHW-1:0]          sh;
    logic [WIDTH:0]          sum_w;
    logic signed [WIDTH:0]   diff_w;
    logic [WIDTH-1:0]        btr_w;

    assign op_multi   = is_multicycle(bus.op);
    assign accept     = bus.in_valid & in_ready;
    assign iter_start = accept & op_multi;
    assign iter_mode  = (bus.op == DIVU) ? MODE_DIV :
                        (bus.op == REMU) ? MODE_REM : MODE_MUL;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.result    = result_q;
    assign bus.flag      = flag_q;
    assign bus.err       = err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = op_multi ? ITER : DONE;
            ITER: if (iter_done) state_d = DONE;
            DONE: begin
                if (accept)             state_d = op_multi ? ITER : DONE;
                else if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
        out_valid = (state_q == DONE);
    end

    seq_alu_iter #(.WIDTH(WIDTH)) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (iter_start),
        .mode   (iter_mode),
        .a      (bus.a),
        .b      (bus.b),
        .done   (iter_done),
        .result (iter_result)
    );

    // Compares use a sign-extended WIDTH+1 difference so min-negative vs max-positive cannot overflow.
    assign sh     = bus.b[SHW-1:0];
    assign sum_w  = {1'b0, bus.a} + {1'b0, bus.b};
    assign diff_w = $signed({bus.a[WIDTH-1], bus.a}) - $signed({bus.b[WIDTH-1], bus.b});

    always_comb begin
        for (int i = 0; i < WIDTH; i++) btr_w[i] = bus.a[WIDTH-1-i];
    end

    always_comb begin
        sc_result = '0;
        sc_flag   = 1'b0;
        sc_err    = 1'b0;
        case (bus.op)
            ADD:  sc_result = sum_w[WIDTH-1:0];
            SUB:  sc_result = bus.b - bus.a;
            XOR:  sc_result = bus.a ^ bus.b;
            ANDN: sc_result = bus.a & ~bus.b;
            ROL:  sc_result = (bus.a << sh) | (bus.a >> (WIDTH - int'(sh)));
            SLL:  sc_result = bus.a << sh;
            ROR:  sc_result = (bus.a >> sh) | (bus.a << (WIDTH - int'(sh)));
            SRL:  sc_result = bus.a >> sh;
            SEQ:  sc_result[0] = (diff_w == 0);
            SLT:  sc_result[0] = (diff_w < 0);
            SLE:  sc_result[0] = (diff_w <= 0);
            SCO:  sc_result[0] = sum_w[WIDTH];
            BTR:  sc_result = btr_w;
            LBI:  sc_result = bus.b;
            SLBI: sc_result = (bus.a << (WIDTH/2)) | bus.b;
            BEQZ: sc_flag = (bus.a == '0);
            BNEZ: sc_flag = (bus.a != '0);
            BLTZ: sc_flag = bus.a[WIDTH-1];
            BGEZ: sc_flag = ~bus.a[WIDTH-1];
            MUL, DIVU, REMU: ;
            default: sc_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_q <= '0;
            flag_q   <= 1'b0;
            err_q    <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            if (accept)
                dz_q <= ((bus.op == DIVU) || (bus.op == REMU)) && (bus.b == '0);
            if (accept && !op_multi) begin
                result_q <= sc_result;
                flag_q   <= sc_flag;
                err_q    <= sc_err;
            end else if ((state_q == ITER) && iter_done) begin
                result_q <= iter_result;
                flag_q   <= 1'b0;
                err_q    <= dz_q;
            end
        end
    end
endmodule

// File: tb/tb_seq_alu.sv
// Directed-vector bench for seq_alu at WIDTH=16 and WIDTH=32.
module tb_seq_alu;
    import seq_alu_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    seq_alu_if #(.WIDTH(16)) if16();
    seq_alu_if #(.WIDTH(32)) if32();

    seq_alu #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));
    seq_alu #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(if32));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic t16(input string tag, input logic [4:0] op_i, input logic [15:0] a_i,
                       input logic [15:0] b_i, input logic [15:0] exp_r,
                       input logic exp_f, input logic exp_e, input int exp_lat);
        int lat;
        if16.op = op_i; if16.a = a_i; if16.b = b_i; if16.in_valid = 1'b1;
        @(posedge clk); #1;
        if16.in_valid = 1'b0; if16.a = ~a_i; if16.b = 16'h5a5a;
        lat = 1;
        while (!if16.out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        chk({tag, ".res"}, 64'(if16.result), 64'(exp_r));
        chk({tag, ".flag"}, 64'(if16.flag), 64'(exp_f));
        chk({tag, ".err"}, 64'(if16.err), 64'(exp_e));
        chk({tag, ".lat"}, 64'(lat), 64'(exp_lat));
    endtask

    task automatic t32(input string tag, input logic [4:0] op_i, input logic [31:0] a_i,
                       input logic [31:0] b_i, input logic [31:0] exp_r,
                       input logic exp_e, input int exp_lat);
        int lat;
        if32.op = op_i; if32.a = a_i; if32.b = b_i; if32.in_valid = 1'b1;
        @(posedge clk); #1;
        if32.in_valid = 1'b0; if32.a = ~a_i; if32.b = 32'h5a5a_5a5a;
        lat = 1;
        while (!if32.out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        chk({tag, ".res"}, 64'(if32.result), 64'(exp_r));
        chk({tag, ".err"}, 64'(if32.err), 64'(exp_e));
        chk({tag, ".lat"}, 64'(lat), 64'(exp_lat));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        if16.in_valid = 1'b0; if16.out_ready = 1'b1; if16.op = '0; if16.a = '0; if16.b = '0;
        if32.in_valid = 1'b0; if32.out_ready = 1'b1; if32.op = '0; if32.a = '0; if32.b = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst.out_valid", 64'(if16.out_valid), 64'd0);
        chk("rst.result", 64'(if16.result), 64'd0);
        chk("rst.in_ready", 64'(if16.in_ready), 64'd1);

        t16("add_wrap", ADD, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1'b0, 1);
        t16("sco",      SCO, 16'hFFFF, 16'h0001, 16'h0001, 1'b0, 1'b0, 1);
        t16("slt_min",  SLT, 16'h8000, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1);
        t16("sle_max",  SLE, 16'h7FFF, 16'h8000, 16'h0000, 1'b0, 1'b0, 1);
        t16("sle_eq",   SLE, 16'h8000, 16'h8000, 16'h0001, 1'b0, 1'b0, 1);
        t16("seq",      SEQ, 16'h0005, 16'h0005, 16'h0001, 1'b0, 1'b0, 1);
        t16("slbi",     SLBI, 16'h0012, 16'h0034, 16'h1234, 1'b0, 1'b0, 1);
        t16("sub",      SUB, 16'h0003, 16'h000A, 16'h0007, 1'b0, 1'b0, 1);
        t16("xor",      XOR, 16'hF0F0, 16'h0FF0, 16'hFF00, 1'b0, 1'b0, 1);
        t16("andn",     ANDN, 16'hFF0F, 16'h00FF, 16'hFF00, 1'b0, 1'b0, 1);
        t16("rol_mask", ROL, 16'h8001, 16'h0011, 16'h0003, 1'b0, 1'b0, 1);
        t16("ror",      ROR, 16'h0001, 16'h0001, 16'h8000, 1'b0, 1'b0, 1);
        t16("sll0",     SLL, 16'h1234, 16'h0000, 16'h1234, 1'b0, 1'b0, 1);
        t16("rol0",     ROL, 16'h1234, 16'h0000, 16'h1234, 1'b0, 1'b0, 1);
        t16("srl15",    SRL, 16'h8000, 16'h000F, 16'h0001, 1'b0, 1'b0, 1);
        t16("btr",      BTR, 16'h1234, 16'h0000, 16'h2C48, 1'b0, 1'b0, 1);
        t16("lbi",      LBI, 16'h1111, 16'hBEEF, 16'hBEEF, 1'b0, 1'b0, 1);
        t16("mul",      MUL, 16'h0123, 16'h0010, 16'h1230, 1'b0, 1'b0, 17);
        t16("mul_ones", MUL, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 17);
        t16("divu",     DIVU, 16'd100, 16'd7, 16'd14, 1'b0, 1'b0, 17);
        t16("remu",     REMU, 16'd100, 16'd7, 16'd2, 1'b0, 1'b0, 17);
        t16("divu_z",   DIVU, 16'h00AB, 16'h0000, 16'hFFFF, 1'b0, 1'b1, 17);
        t16("remu_z",   REMU, 16'h00AB, 16'h0000, 16'h00AB, 1'b0, 1'b1, 17);
        t16("bltz",     BLTZ, 16'h8000, 16'h0000, 16'h0000, 1'b1, 1'b0, 1);
        t16("bgez",     BGEZ, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 1);
        t16("beqz",     BEQZ, 16'h0005, 16'h0000, 16'h0000, 1'b0, 1'b0, 1);
        t16("bnez",     BNEZ, 16'h0005, 16'h0000, 16'h0000, 1'b1, 1'b0, 1);
        t16("illegal",  5'd25, 16'h1234, 16'h5678, 16'h0000, 1'b0, 1'b1, 1);

        // Backpressure: drain, then issue with out_ready low and hold.
        if16.out_ready = 1'b1;
        @(posedge clk); #1;
        if16.out_ready = 1'b0;
        if16.op = ADD; if16.a = 16'd1; if16.b = 16'd2; if16.in_valid = 1'b1;
        @(posedge clk); #1;
        if16.in_valid = 1'b0; if16.a = 16'hDEAD; if16.b = 16'hBEEF;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp.result", 64'(if16.result), 64'd3);
            chk("bp.out_valid", 64'(if16.out_valid), 64'd1);
            chk("bp.in_ready", 64'(if16.in_ready), 64'd0);
        end
        if16.op = ADD; if16.a = 16'd4; if16.b = 16'd5; if16.in_valid = 1'b1; if16.out_ready = 1'b1;
        #1 chk("bp.ready_on_consume", 64'(if16.in_ready), 64'd1);
        @(posedge clk); #1;
        if16.in_valid = 1'b0;
        chk("bp.nobubble_valid", 64'(if16.out_valid), 64'd1);
        chk("bp.nobubble_result", 64'(if16.result), 64'd9);

        // Reset in the middle of a multiply.
        if16.op = MUL; if16.a = 16'd3; if16.b = 16'd5; if16.in_valid = 1'b1;
        @(posedge clk); #1;
        if16.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("midrst.out_valid", 64'(if16.out_valid), 64'd0);
        chk("midrst.result", 64'(if16.result), 64'd0);
        chk("midrst.in_ready", 64'(if16.in_ready), 64'd1);
        repeat (20) @(posedge clk);
        #1 chk("midrst.abandoned", 64'(if16.out_valid), 64'd0);

        t32("add32_wrap", ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1);
        t32("divu32",     DIVU, 32'd100, 32'd7, 32'd14, 1'b0, 33);
        t32("rol32",      ROL, 32'h8000_0001, 32'h0000_0001, 32'h0000_0003, 1'b0, 1);
        t32("divu32_z",   DIVU, 32'h0000_00AB, 32'h0, 32'hFFFF_FFFF, 1'b1, 33);

        @(posedge clk); #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
